// File: rtl/multi_score_counter.sv
// N-player BCD score counter: each increment/clear button is synchronised, debounced and
// edge-detected on its own, then drives that player's score.
module multi_score_counter #(
    parameter int NUM_PLAYERS    = 2,
    parameter int NUM_DIGITS     = 1,
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int WRAP_EN        = 1
) (
    input  logic                              i_Clk,
    input  logic                              i_Reset,
    input  logic [NUM_PLAYERS-1:0]            i_Inc,
    input  logic [NUM_PLAYERS-1:0]            i_Clr,
    output logic [NUM_PLAYERS*NUM_DIGITS*4-1:0] o_Score,
    output logic [NUM_PLAYERS-1:0]            o_At_Max,
    output logic [NUM_PLAYERS-1:0]            o_Wrap
);

    localparam int NUM_IN = 2 * NUM_PLAYERS;
    localparam int CNT_W  = $clog2(DEBOUNCE_LIMIT);
    localparam int SW     = NUM_DIGITS * 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    // Input bits: increments in the low half, clears in the high half.
    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] sync1;
    logic [NUM_IN-1:0] sync2;
    logic [NUM_IN-1:0] deb;
    logic [NUM_IN-1:0] hist;
    logic [NUM_IN-1:0] press_q;
    logic [CNT_W-1:0]  cnt [NUM_IN];

    logic [NUM_PLAYERS-1:0] inc_ev;
    logic [NUM_PLAYERS-1:0] clr_ev;

    logic [SW-1:0]          score [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] wrap_q;

    assign raw    = {i_Clr, i_Inc};
    assign inc_ev = press_q[NUM_PLAYERS-1:0];
    assign clr_ev = press_q[NUM_IN-1:NUM_PLAYERS];

    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (carry) begin
                if (v[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic is_max(input logic [SW-1:0] v);
        logic m;
        m = 1'b1;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (v[d*4 +: 4] != 4'd9) m = 1'b0;
        end
        return m;
    endfunction

    // Press pulse is registered so a score update lands LIMIT+3 edges after the raw edge.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1   <= '0;
            sync2   <= '0;
            deb     <= '0;
            hist    <= '0;
            press_q <= '0;
            for (int i = 0; i < NUM_IN; i++) cnt[i] <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            hist    <= deb;
            press_q <= deb & ~hist;
            for (int i = 0; i < NUM_IN; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        deb[i] <= sync2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            wrap_q <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) score[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                wrap_q[p] <= 1'b0;
                if (clr_ev[p]) begin
                    score[p] <= '0;
                end else if (inc_ev[p]) begin
                    if (is_max(score[p])) begin
                        if (WRAP_EN != 0) begin
                            score[p]  <= '0;
                            wrap_q[p] <= 1'b1;
                        end
                    end else begin
                        score[p] <= bcd_inc(score[p]);
                    end
                end
            end
        end
    end

    genvar gp;
    generate
        for (gp = 0; gp < NUM_PLAYERS; gp++) begin : g_out
            assign o_Score[gp*SW +: SW] = score[gp];
            assign o_At_Max[gp]         = is_max(score[gp]);
        end
    endgenerate

    assign o_Wrap = wrap_q;

endmodule

// File: tb/tb_multi_score_counter.sv
// Bench for multi_score_counter: a wrapping and a saturating instance share the buttons;
// stimulus queues timed expected states, a negedge monitor checks every cycle.
module tb_multi_score_counter;

    localparam int NP = 2;
    localparam int ND = 2;
    localparam int DL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  inc = '0;
    logic [1:0]  clr = '0;
    logic [15:0] score_w, score_s;
    logic [1:0]  max_w, max_s, wrap_w, wrap_s;

    multi_score_counter #(.NUM_PLAYERS(NP), .NUM_DIGITS(ND), .DEBOUNCE_LIMIT(DL), .WRAP_EN(1)) dut_w (
        .i_Clk(clk), .i_Reset(rst), .i_Inc(inc), .i_Clr(clr),
        .o_Score(score_w), .o_At_Max(max_w), .o_Wrap(wrap_w)
    );

    multi_score_counter #(.NUM_PLAYERS(NP), .NUM_DIGITS(ND), .DEBOUNCE_LIMIT(DL), .WRAP_EN(0)) dut_s (
        .i_Clk(clk), .i_Reset(rst), .i_Inc(inc), .i_Clr(clr),
        .o_Score(score_s), .o_At_Max(max_s), .o_Wrap(wrap_s)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: {due cycle[65:34], wrap-instance scores[33:18], sat-instance scores[17:2], wrap pulses[1:0]}
    logic [65:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int m_w[2] = '{0, 0};
    int m_s[2] = '{0, 0};

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic push_exp(input int unsigned due, input logic [1:0] wr);
        exp_q.push_back({32'(due), to_bcd(m_w[1]), to_bcd(m_w[0]),
                         to_bcd(m_s[1]), to_bcd(m_s[0]), wr});
    endtask

    // Decimal reference: clear beats increment, wrap instance rolls 99->0, sat instance sticks.
    task automatic apply_model(input logic [1:0] i, input logic [1:0] c, output logic [1:0] wr);
        wr = '0;
        for (int p = 0; p < 2; p++) begin
            if (c[p]) begin
                m_w[p] = 0;
                m_s[p] = 0;
            end else if (i[p]) begin
                if (m_w[p] == 99) begin
                    m_w[p] = 0;
                    wr[p]  = 1'b1;
                end else begin
                    m_w[p] = m_w[p] + 1;
                end
                if (m_s[p] < 99) m_s[p] = m_s[p] + 1;
            end
        end
    endtask

    // Driver tasks; always entered just after a rising edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [1:0] i, input logic [1:0] c, input int hold, input int gap);
        logic [1:0] wr;
        apply_model(i, c, wr);
        push_exp(cyc + 8, wr);
        inc = i;
        clr = c;
        tick(hold);
        inc = '0;
        clr = '0;
        tick(gap);
    endtask

    // Monitor
    logic [15:0] cur_w  = '0;
    logic [15:0] cur_s  = '0;
    logic [1:0]  cur_wr = '0;

    always @(negedge clk) begin : monitor
        logic [65:0] h;
        logic [1:0]  emw, ems;
        cur_wr = '0;
        if (cyc >= 1) begin
            if (exp_q.size() > 0) begin
                h = exp_q[0];
                if (h[65:34] == cyc) begin
                    void'(exp_q.pop_front());
                    cur_w  = h[33:18];
                    cur_s  = h[17:2];
                    cur_wr = h[1:0];
                end
            end
            emw = {cur_w[15:8] == 8'h99, cur_w[7:0] == 8'h99};
            ems = {cur_s[15:8] == 8'h99, cur_s[7:0] == 8'h99};
            checks++;
            if ({score_w, score_s, wrap_w, wrap_s, max_w, max_s} !==
                {cur_w, cur_s, cur_wr, 2'b00, emw, ems}) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL state cyc=%0d got score_w=%h score_s=%h wrap_w=%b wrap_s=%b max_w=%b max_s=%b exp score_w=%h score_s=%h wrap_w=%b wrap_s=00 max_w=%b max_s=%b",
                             cyc, score_w, score_s, wrap_w, wrap_s, max_w, max_s,
                             cur_w, cur_s, cur_wr, emw, ems);
            end
        end
    end

    initial begin
        logic [1:0] wr;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Single press: player 0 -> 01 exactly 7 edges after the sampling edge
        press(2'b01, 2'b00, 20, 8);

        // Short glitches are ignored
        repeat (10) begin
            inc = 2'b01;
            tick(2);
            inc = 2'b00;
            tick(2);
        end
        tick(6);

        // 9 clean presses: 01 -> 10 across the 09 -> 10 carry
        repeat (9) press(2'b01, 2'b00, 6, 8);

        // Clear, climb to 99, then wrap (wrap instance) vs saturate (sat instance)
        press(2'b00, 2'b01, 6, 8);
        repeat (99) press(2'b01, 2'b00, 6, 8);
        press(2'b01, 2'b00, 6, 8);
        press(2'b01, 2'b00, 6, 8);

        // Simultaneous presses on both players; clear wins over increment
        press(2'b11, 2'b00, 6, 8);
        press(2'b00, 2'b10, 6, 8);
        repeat (42) press(2'b10, 2'b00, 6, 8);
        press(2'b10, 2'b10, 6, 8);

        // Long hold counts once; press after release counts again
        press(2'b01, 2'b00, 100, 10);
        press(2'b01, 2'b00, 6, 8);

        // Reset mid-debounce with scores 37/05, button held through reset release
        press(2'b00, 2'b11, 6, 8);
        repeat (5) press(2'b11, 2'b00, 6, 8);
        repeat (32) press(2'b01, 2'b00, 6, 8);
        inc = 2'b01;
        tick(2);
        rst = 1'b1;
        m_w = '{0, 0};
        m_s = '{0, 0};
        push_exp(cyc + 1, 2'b00);
        tick(3);
        rst = 1'b0;
        apply_model(2'b01, 2'b00, wr);
        push_exp(cyc + 8, wr);
        tick(20);
        inc = 2'b00;
        tick(10);

        // Drain
        for (int k = 0; k < 50 && exp_q.size() > 0; k++) tick(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected entries, need 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
